// File: rtl/fifo_stream_reader.sv
// Read-side consumer for a synchronous FIFO: issues reads and absorbs the 1-cycle
// read latency in a 2-entry in-order buffer, which feeds a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  idle
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_word_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_level;

  assign w_pop  = m_valid && m_ready;
  assign w_push = r_inflight;

  // Words held plus words already requested, less the one leaving this cycle.
  // Counting the pop lets m_ready open a read slot in the same cycle.
  assign w_level = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);

  assign fifo_read_en = !rst && en && !fifo_empty && (w_level < 3'd2);
  assign m_valid      = (r_occ != 2'd0);
  assign m_data       = r_head;
  assign word_cnt     = r_word_cnt;
  assign idle         = (r_occ == 2'd0) && !r_inflight && fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
      r_head     <= '0;
    end else begin
      r_inflight <= fifo_read_en;
      r_occ      <= r_occ + 2'(w_push) - 2'(w_pop);
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
      end
      if (w_pop) begin
        if (r_occ == 2'd2) begin
          r_head <= r_tail;
        end else if (w_push) begin
          r_head <= fifo_data_out;
        end
      end else if (w_push && (r_occ == 2'd0)) begin
        r_head <= fifo_data_out;
      end
`ifndef SYNTHESIS
      assert (!(w_push && !w_pop && (r_occ == 2'd2)))
        else $error("fifo_stream_reader: push into full output buffer");
`endif
    end
  end

  // NOTE: the second buffer slot is only read after it has been written, so it
  // carries no reset; occ alone defines which slots hold live data.
  always_ff @(posedge clk) begin
    if (w_push && (((r_occ == 2'd1) && !w_pop) || ((r_occ == 2'd2) && w_pop))) begin
      r_tail <= fifo_data_out;
    end
  end

endmodule
